// File: rtl/button_conditioner_pkg.sv
// Shared encodings and defaults for the push-button conditioner.
// Channel state and owner encodings are fixed because other blocks decode them.
package button_conditioner_pkg;

    localparam int unsigned DEFAULT_CNT_W = 20;
    localparam logic [DEFAULT_CNT_W-1:0] DEFAULT_DEBOUNCE_CYCLES = 20'd500000;

    typedef enum logic [1:0] {
        StIdle           = 2'd0,
        StConfirmPress   = 2'd1,
        StPressed        = 2'd2,
        StConfirmRelease = 2'd3
    } chan_state_e;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnUp   = 2'd1,
        OwnDown = 2'd2
    } owner_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned level/pulse outputs of the conditioner.
// master drives the raw buttons; slave is the conditioner itself.
interface button_conditioner_if;

    logic btn_up_raw;
    logic btn_down_raw;
    logic userOpcUp;
    logic userOpcDown;
    logic up_pulse;
    logic down_pulse;

    modport master (
        output btn_up_raw, btn_down_raw,
        input  userOpcUp, userOpcDown, up_pulse, down_pulse
    );

    modport slave (
        input  btn_up_raw, btn_down_raw,
        output userOpcUp, userOpcDown, up_pulse, down_pulse
    );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM and hold counter.
// stable follows the synchronized input only after it has held for DEBOUNCE_CYCLES.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned       CNT_W           = DEFAULT_CNT_W,
    parameter logic [CNT_W-1:0]  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] LAST = DEBOUNCE_CYCLES - 1'b1;

    logic              sync1_q;
    logic              sync2_q;
    chan_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              stable_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (sync2_q) state_q <= StConfirmPress;
                end
                StConfirmPress: begin
                    if (!sync2_q) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q  <= StPressed;
                        cnt_q    <= '0;
                        stable_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    cnt_q <= '0;
                    if (!sync2_q) state_q <= StConfirmRelease;
                end
                StConfirmRelease: begin
                    // A bounce back to 1 cancels the release; stable never dips.
                    if (sync2_q) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q  <= StIdle;
                        cnt_q    <= '0;
                        stable_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the up/down buttons and arbitrates them into mutually exclusive levels.
// A channel is only granted on a fresh rise of its stable signal, never by inheritance.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned       CNT_W           = DEFAULT_CNT_W,
    parameter logic [CNT_W-1:0]  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    logic   stable_up;
    logic   stable_down;
    logic   prev_up_q;
    logic   prev_down_q;
    logic   rise_up;
    logic   rise_down;
    logic   owner_free;
    owner_e owner_q;
    owner_e owner_d;
    logic   up_d;
    logic   down_d;
    logic   up_q;
    logic   down_q;
    logic   up_pulse_q;
    logic   down_pulse_q;

    debounce_channel #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up (
        .clk    (clk),
        .rst    (rst),
        .raw    (bus.btn_up_raw),
        .stable (stable_up)
    );

    debounce_channel #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_down (
        .clk    (clk),
        .rst    (rst),
        .raw    (bus.btn_down_raw),
        .stable (stable_down)
    );

    always_comb begin
        rise_up    = stable_up & ~prev_up_q;
        rise_down  = stable_down & ~prev_down_q;
        owner_free = (owner_q == OwnNone) ||
                     (owner_q == OwnUp && !stable_up) ||
                     (owner_q == OwnDown && !stable_down);
        owner_d = owner_q;
        if (owner_free) begin
            if (rise_up)        owner_d = OwnUp;
            else if (rise_down) owner_d = OwnDown;
            else                owner_d = OwnNone;
        end
        up_d   = (owner_d == OwnUp) && stable_up;
        down_d = (owner_d == OwnDown) && stable_down;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_up_q    <= 1'b0;
            prev_down_q  <= 1'b0;
            owner_q      <= OwnNone;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            up_pulse_q   <= 1'b0;
            down_pulse_q <= 1'b0;
        end else begin
            prev_up_q    <= stable_up;
            prev_down_q  <= stable_down;
            owner_q      <= owner_d;
            up_q         <= up_d;
            down_q       <= down_d;
            up_pulse_q   <= up_d & ~up_q;
            down_pulse_q <= down_d & ~down_q;
        end
    end

    assign bus.userOpcUp   = up_q;
    assign bus.userOpcDown = down_q;
    assign bus.up_pulse    = up_pulse_q;
    assign bus.down_pulse  = down_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing buttons,
// every cycle compared against a run-length debounce and arbitration model.
module tb_button_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    button_conditioner_if bus ();

    button_conditioner #(
        .CNT_W           (3),
        .DEBOUNCE_CYCLES (3'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: per button, raw delayed two edges; stable flips after D+1 consecutive
    // disagreeing samples. Owner granted only on a stable rise, released on its fall.
    bit m_s1[2], m_s2[2], m_stab[2], m_prev[2], m_out[2], m_pulse[2];
    int m_run[2];
    int m_owner;

    int up_pulses, down_pulses, setpoint;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_prev[i] = 0;
            m_out[i] = 0; m_pulse[i] = 0; m_run[i] = 0;
        end
        m_owner = 0;
    endfunction

    function automatic void model_step(input bit raw_up, input bit raw_dn);
        bit rise[2];
        bit owner_held;
        bit nout;
        int nowner;
        for (int i = 0; i < 2; i++) rise[i] = m_stab[i] && !m_prev[i];
        case (m_owner)
            1:       owner_held = m_stab[0];
            2:       owner_held = m_stab[1];
            default: owner_held = 0;
        endcase
        if (owner_held)   nowner = m_owner;
        else if (rise[0]) nowner = 1;
        else if (rise[1]) nowner = 2;
        else              nowner = 0;
        for (int i = 0; i < 2; i++) begin
            nout       = (nowner == i + 1) && m_stab[i];
            m_pulse[i] = nout && !m_out[i];
            m_out[i]   = nout;
            m_prev[i]  = m_stab[i];
        end
        m_owner = nowner;
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    m_stab[i] = !m_stab[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
        m_s1[0] = raw_up;  m_s1[1] = raw_dn;
    endfunction

    task automatic compare_outputs();
        check_eq("up_level",   32'(bus.userOpcUp),   32'(m_out[0]));
        check_eq("down_level", 32'(bus.userOpcDown), 32'(m_out[1]));
        check_eq("up_pulse",   32'(bus.up_pulse),    32'(m_pulse[0]));
        check_eq("down_pulse", 32'(bus.down_pulse),  32'(m_pulse[1]));
        check_eq("mutex",      32'(bus.userOpcUp & bus.userOpcDown), 32'd0);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_step(bus.btn_up_raw, bus.btn_down_raw);
            else     model_reset();
            #1;
            compare_outputs();
            if (bus.up_pulse === 1'b1) begin
                up_pulses++;
                if (setpoint < 10) setpoint++;
            end
            if (bus.down_pulse === 1'b1) begin
                down_pulses++;
                if (setpoint > 0) setpoint--;
            end
        end
    endtask

    initial begin
        int hold[2];
        bus.btn_up_raw   = 1'b0;
        bus.btn_down_raw = 1'b0;
        model_reset();
        up_pulses = 0; down_pulses = 0; setpoint = 0;

        // Reset held while inputs toggle, then released with inputs low.
        #1;
        compare_outputs();
        for (int i = 0; i < 6; i++) begin
            bus.btn_up_raw   = i[0];
            bus.btn_down_raw = ~i[0];
            tick(1);
        end
        bus.btn_up_raw = 1'b0; bus.btn_down_raw = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(4);
        check_eq("t1_up_idle", 32'(bus.userOpcUp), 32'd0);

        // Bouncing up press, then a clean hold.
        up_pulses = 0; down_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            bus.btn_up_raw = ((i / 2) % 2) == 0;
            tick(1);
        end
        check_eq("t2_bounce_quiet", 32'(up_pulses), 32'd0);
        bus.btn_up_raw = 1'b1;
        tick(7);
        check_eq("t2_not_yet", 32'(bus.userOpcUp), 32'd0);
        tick(1);
        check_eq("t2_up", 32'(bus.userOpcUp), 32'd1);
        tick(5);
        check_eq("t2_up_pulses", 32'(up_pulses), 32'd1);
        check_eq("t2_down_pulses", 32'(down_pulses), 32'd0);

        // Release with a 2-cycle glitch back to pressed.
        bus.btn_up_raw = 1'b0; tick(2);
        bus.btn_up_raw = 1'b1; tick(2);
        check_eq("t3_glitch_hold", 32'(bus.userOpcUp), 32'd1);
        bus.btn_up_raw = 1'b0;
        tick(7);
        check_eq("t3_still_up", 32'(bus.userOpcUp), 32'd1);
        tick(1);
        check_eq("t3_released", 32'(bus.userOpcUp), 32'd0);
        tick(4);
        check_eq("t3_no_repulse", 32'(up_pulses), 32'd1);

        // Simultaneous press: up wins; down needs a fresh press.
        bus.btn_up_raw = 1'b1; bus.btn_down_raw = 1'b1;
        tick(10);
        check_eq("t4_up_wins", 32'(bus.userOpcUp), 32'd1);
        check_eq("t4_down_lose", 32'(bus.userOpcDown), 32'd0);
        bus.btn_up_raw = 1'b0;
        tick(10);
        check_eq("t4_up_off", 32'(bus.userOpcUp), 32'd0);
        check_eq("t4_no_inherit", 32'(bus.userOpcDown), 32'd0);
        bus.btn_down_raw = 1'b0;
        tick(10);
        down_pulses = 0;
        bus.btn_down_raw = 1'b1;
        tick(10);
        check_eq("t4_down_on", 32'(bus.userOpcDown), 32'd1);
        check_eq("t4_down_pulses", 32'(down_pulses), 32'd1);

        // Reset mid-press: outputs drop at once, full re-qualification after.
        rst = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        check_eq("t5_async_drop", 32'(bus.userOpcDown), 32'd0);
        tick(1);
        rst = 1'b1;
        down_pulses = 0;
        tick(7);
        check_eq("t5_not_yet", 32'(bus.userOpcDown), 32'd0);
        tick(5);
        check_eq("t5_down_back", 32'(bus.userOpcDown), 32'd1);
        check_eq("t5_down_pulses", 32'(down_pulses), 32'd1);
        bus.btn_down_raw = 1'b0;
        tick(10);

        // Eleven up presses drive a saturating counter to 10, eleven downs back to 0.
        up_pulses = 0; down_pulses = 0; setpoint = 0;
        repeat (11) begin
            bus.btn_up_raw = 1'b1; tick(10);
            bus.btn_up_raw = 1'b0; tick(10);
        end
        check_eq("t6_up_pulses", 32'(up_pulses), 32'd11);
        check_eq("t6_setpoint_top", 32'(setpoint), 32'd10);
        repeat (11) begin
            bus.btn_down_raw = 1'b1; tick(10);
            bus.btn_down_raw = 1'b0; tick(10);
        end
        check_eq("t6_down_pulses", 32'(down_pulses), 32'd11);
        check_eq("t6_setpoint_bot", 32'(setpoint), 32'd0);

        // Random bouncing on both buttons.
        hold[0] = 0; hold[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold[0] == 0) begin
                bus.btn_up_raw = 1'($urandom_range(0, 1));
                hold[0] = int'($urandom_range(1, 9));
            end
            if (hold[1] == 0) begin
                bus.btn_down_raw = 1'($urandom_range(0, 1));
                hold[1] = int'($urandom_range(1, 9));
            end
            hold[0]--; hold[1]--;
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
